// File: rtl/alu_shift_right_seq.sv
// Multi-cycle right shifter (SRL/SRA), one bit position per clock, with start/busy/done handshake.
// Flags follow ALU_16: z = result is zero, n = result MSB, v always 0.
module alu_shift_right_seq #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             arith,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] amt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             z,
  output logic             v,
  output logic             n
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(WIDTH);
  localparam logic [WIDTH-1:0] AmtMax = WIDTH'(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             arith_q, arith_d;
  logic             z_q, z_d;

  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    arith_d  = arith_q;
    z_d      = z_q;
    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StShift;
          work_d  = a;
          arith_d = arith;
          // Amounts of WIDTH or more all saturate to a full-width shift.
          cnt_d   = (amt >= AmtMax) ? CntMax : amt[CNT_W-1:0];
        end else begin
          state_d = StIdle;
        end
      end
      StShift: begin
        if (cnt_q != '0) begin
          work_d = {arith_q & work_q[WIDTH-1], work_q[WIDTH-1:1]};
          cnt_d  = cnt_q - CNT_W'(1);
        end else begin
          result_d = work_q;
          z_d      = (work_q == '0);
          state_d  = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      work_q   <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      arith_q  <= 1'b0;
      z_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      arith_q  <= arith_d;
      z_q      <= z_d;
    end
  end

  assign busy   = (state_q == StShift);
  assign done   = (state_q == StDone);
  assign result = result_q;
  assign z      = z_q;
  assign n      = result_q[WIDTH-1];
  assign v      = 1'b0;

endmodule

// File: tb/tb_alu_shift_right_seq.sv
// Scoreboard bench for alu_shift_right_seq: the driver queues expected results, a monitor
// checks every done pulse, its latency, and that outputs hold between completions.
module tb_alu_shift_right_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        arith = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] amt = '0;
  logic        busy, done, z, v, n;
  logic [15:0] result;

  alu_shift_right_seq #(.WIDTH(16), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .arith(arith), .a(a), .amt(amt),
    .busy(busy), .done(done), .result(result), .z(z), .v(v), .n(n)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] res;
    int          edge_n;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  int          ecnt = 0;
  logic [15:0] held_r = '0;
  logic        held_z = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: widen with the fill bit, then a plain right shift of the saturated amount.
  function automatic logic [15:0] model(input logic [15:0] av, input logic [15:0] sh,
                                        input logic ar);
    int          k;
    logic [31:0] ext;
    k   = (sh >= 16) ? 16 : int'(sh);
    ext = ar ? {{16{av[15]}}, av} : {16'h0000, av};
    ext = ext >> k;
    return ext[15:0];
  endfunction

  initial forever begin
    @(posedge clk);
    ecnt++;
  end

  // Monitor: every done must match the oldest queued expectation; otherwise outputs hold.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!rst_n) begin
      held_r = '0;
      held_z = 1'b0;
    end else if (done) begin
      if (sb.size() == 0) begin
        check("spurious_done", 32'(done), 32'd0);
      end else begin
        e = sb.pop_front();
        check("result", 32'(result), 32'(e.res));
        check("z", 32'(z), 32'(e.res == 16'h0000));
        check("n", 32'(n), 32'(e.res[15]));
        check("v", 32'(v), 32'd0);
        check("latency_edge", 32'(ecnt), 32'(e.edge_n));
        held_r = e.res;
        held_z = (e.res == 16'h0000);
      end
    end else begin
      check("hold", {13'd0, result, z, n, v}, {13'd0, held_r, held_z, held_r[15], 1'b0});
    end
  end

  // Called at a negedge; returns at the negedge after the capture edge.
  task automatic start_op(input logic [15:0] av, input logic [15:0] sh, input logic ar,
                          input logic [15:0] exp_res);
    exp_t e;
    int   k;
    for (int i = 0; i < 60 && busy; i++) @(negedge clk);
    if (busy) check("start_wait_timeout", 32'(busy), 32'd0);
    k        = (sh >= 16) ? 16 : int'(sh);
    e.res    = exp_res;
    e.edge_n = ecnt + k + 2;
    sb.push_back(e);
    start = 1'b1;
    a     = av;
    amt   = sh;
    arith = ar;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = 16'($urandom);
    amt   = 16'($urandom);
    arith = 1'($urandom);
    @(negedge clk);
    check("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 60 && !done; i++) @(negedge clk);
    if (!done) check("done_timeout", 32'(done), 32'd1);
  endtask

  initial begin
    logic [15:0] ra, rs;
    logic        rr;
    // Reset state
    #3;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_flags", {29'd0, z, v, n}, 32'd0);
    check("rst_result", 32'(result), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors
    start_op(16'hAA00, 16'd4, 1'b0, 16'h0AA0);    wait_done();
    start_op(16'h8000, 16'd15, 1'b1, 16'hFFFF);   wait_done();
    start_op(16'h8000, 16'd15, 1'b0, 16'h0001);   wait_done();
    start_op(16'h00FF, 16'd8, 1'b0, 16'h0000);    wait_done();
    start_op(16'h1234, 16'd0, 1'b0, 16'h1234);    wait_done();
    start_op(16'h8001, 16'h0100, 1'b1, 16'hFFFF); wait_done();
    start_op(16'h8001, 16'h0100, 1'b0, 16'h0000); wait_done();
    start_op(16'h8001, 16'd16, 1'b1, 16'hFFFF);   wait_done();
    @(negedge clk);
    @(negedge clk);

    // Start while busy is ignored; the queued op stays the only expected completion
    start_op(16'hAA00, 16'd4, 1'b0, 16'h0AA0);
    start = 1'b1;
    a     = 16'hFFFF;
    amt   = 16'd0;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done();
    // Back-to-back: start issued while in DONE
    start_op(16'hF0F0, 16'd3, 1'b1, 16'hFE1E);
    wait_done();
    @(negedge clk);

    // Reset mid-shift aborts with no done and clears outputs at once
    start_op(16'h7FFF, 16'd10, 1'b0, 16'h001F);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_result", 32'(result), 32'd0);
    check("abort_flags", {29'd0, z, v, n}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_op(16'h9234, 16'd2, 1'b1, 16'hE48D);
    wait_done();

    // Randomized ops, mixing back-to-back and idle gaps
    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom);
      rr = 1'($urandom);
      rs = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 17));
      start_op(ra, rs, rr, model(ra, rs, rr));
      wait_done();
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
